xgmii_loop_mon: RTL
===================

// Module: xgmii_loop_mon
// PURPOSE
//  Parametrised N-channel XGMII interposer between xge_mac and PCS_core on the 156.25 MHz domain.
//  Per channel it forwards TX and RX words with one register stage.
//  It provides near-end loopback (MAC TX -> MAC RX), entered and left only on frame boundaries.
//  It also keeps saturating per-channel frame and error counters, read through a select port.
// PARAMETERS
//  NUM_CH  4   number of XGMII channels
//  DATA_W  64  XGMII data width per channel; CTRL_W = DATA_W/8
//  CNT_W   32  counter width
// PORTS
//  clk_156      in   1                clock, all logic on rising edge
//  async_reset  in   1                asynchronous, active-high reset
//  mac_txd      in   NUM_CH*DATA_W    MAC TX data; ch k at [k*DATA_W +: DATA_W]
//  mac_txc      in   NUM_CH*CTRL_W    MAC TX control
//  pcs_txd      out  NUM_CH*DATA_W    to PCS TX
//  pcs_txc      out  NUM_CH*CTRL_W
//  pcs_rxd      in   NUM_CH*DATA_W    from PCS RX
//  pcs_rxc      in   NUM_CH*CTRL_W
//  mac_rxd      out  NUM_CH*DATA_W    to MAC RX
//  mac_rxc      out  NUM_CH*CTRL_W
//  loop_req     in   NUM_CH           level request: 1 = loopback wanted on channel k
//  loop_act     out  NUM_CH           1 = channel k is in LOOP
//  cnt_ch_sel   in   $clog2(NUM_CH)   counter channel select (min width 1)
//  cnt_typ_sel  in   2                0 TX SOF, 1 RX SOF, 2 TX ERR, 3 RX ERR
//  cnt_rd_data  out  CNT_W            selected counter, 1-cycle registered
//  cnt_clr      in   1                synchronous pulse, clears all counters
// BEHAVIOUR
//  Reset values:
//   - pcs_txd/mac_rxd = all bytes 0x07; pcs_txc/mac_rxc = all ones (idle).
//   - loop_act = 0; cnt_rd_data = 0; all counters 0; all FSMs in NORM.
//  Definitions:
//   - Idle word: every ctrl bit 1 and every byte 0x07.
//   - SOF: byte 0 or byte 4 = 0xFB with its ctrl bit 1.
//   - ERR: any byte = 0xFE with its ctrl bit 1; counts at most 1 per word.
//  TX path: pcs_tx* <= mac_tx* every cycle in all states (loopback also transmits). Latency 1.
//  RX path, per-channel FSM (mac_rx* is registered, latency 1):
//   NORM:   mac_rx <= pcs_rx.
//           loop_req=1 and pcs_rx idle -> LWAIT; mac_rx takes idle that cycle.
//   LWAIT:  mac_rx <= idle.
//           loop_req=0 and pcs_rx idle -> NORM.
//           else mac_tx idle -> LOOP; mac_rx takes idle that cycle.
//   LOOP:   mac_rx <= mac_tx; loop_act=1.
//           loop_req=0 and mac_tx idle -> UWAIT; mac_rx takes idle that cycle.
//   UWAIT:  mac_rx <= idle.
//           pcs_rx idle -> NORM (forwarding resumes next word).
//           loop_req=1 in UWAIT and mac_tx idle -> LOOP.
//  Result: the MAC never sees a truncated frame; a transition costs at least 1 idle word.
//  Counters:
//   - TX SOF/ERR sample mac_tx; RX SOF/ERR sample the word driven onto mac_rx.
//   - Saturate at 2^CNT_W-1, never wrap.
//   - cnt_clr has priority over a same-cycle increment: result 0.
//  Readout: cnt_rd_data <= counter[cnt_ch_sel][cnt_typ_sel]; cnt_ch_sel >= NUM_CH returns 0.
//  Reset mid-frame or mid-transition: outputs go idle immediately, FSM returns to NORM.
// STRUCTURE
//  - xgmii_defs.vh: XGMII_IDLE=8'h07, XGMII_START=8'hFB, XGMII_TERM=8'hFD, XGMII_ERROR=8'hFE;
//    FSM encodings NORM/LWAIT/LOOP/UWAIT; counter type codes.
//  - Sub-module xgmii_loop_chan: one channel's FSM, datapath registers and 4 counters.
//    Top generates NUM_CH instances plus the readout mux.
// TESTING
//  1. Reset, idle both sides, NUM_CH=4 -> all outputs idle, loop_act=0, every counter reads 0.
//  2. Ch0: 3 frames MAC->PCS, 2 frames PCS->MAC, ch1-3 idle
//     -> ch0 TX SOF=3, RX SOF=2, frames byte-exact 1 cycle late; ch1-3 counters 0.
//  3. loop_req[2]=1 raised mid PCS RX frame
//     -> that frame delivered complete, then >=1 idle word, then loop_act[2]=1 at the next MAC TX idle;
//        MAC TX frames appear on mac_rx and pcs_tx.
//  4. loop_req[2] dropped mid MAC TX frame
//     -> frame finishes looped, UWAIT idles, NORM only at a pcs_rx idle; no partial frame on mac_rx.
//  5. CNT_W=4: 20 TX frames with 0xFE injected in 17
//     -> TX SOF=15, TX ERR=15; cnt_clr on the same cycle as an SOF -> reads 0.
//  6. async_reset asserted in LOOP mid-frame
//     -> outputs idle the same cycle, loop_act=0; after release with loop_req still 1, loopback re-enters via LWAIT.

Source files
------------

// File: rtl/xgmii_loop_mon_pkg.sv
// Shared XGMII character codes, loopback FSM states and counter type codes
// for the XGMII loopback monitor.
package xgmii_loop_mon_pkg;

  localparam logic [7:0] XgmiiIdle  = 8'h07;
  localparam logic [7:0] XgmiiStart = 8'hFB;
  localparam logic [7:0] XgmiiError = 8'hFE;

  localparam int unsigned NumCntTyp = 4;

  typedef enum logic [1:0] {
    StNorm,
    StLwait,
    StLoop,
    StUwait
  } loop_state_e;

  typedef enum logic [1:0] {
    CntTxSof = 2'd0,
    CntRxSof = 2'd1,
    CntTxErr = 2'd2,
    CntRxErr = 2'd3
  } cnt_typ_e;

endpackage

// File: rtl/xgmii_loop_mon_chan.sv
// One XGMII channel: registered TX/RX forwarding, frame-boundary loopback FSM
// and four saturating frame/error counters.
module xgmii_loop_mon_chan
  import xgmii_loop_mon_pkg::*;
#(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned CNT_W  = 32
) (
  input  logic                            clk_156,
  input  logic                            async_reset,
  input  logic [DATA_W-1:0]               mac_txd,
  input  logic [DATA_W/8-1:0]             mac_txc,
  output logic [DATA_W-1:0]               pcs_txd,
  output logic [DATA_W/8-1:0]             pcs_txc,
  input  logic [DATA_W-1:0]               pcs_rxd,
  input  logic [DATA_W/8-1:0]             pcs_rxc,
  output logic [DATA_W-1:0]               mac_rxd,
  output logic [DATA_W/8-1:0]             mac_rxc,
  input  logic                            loop_req,
  output logic                            loop_act,
  input  logic                            cnt_clr,
  output logic [NumCntTyp-1:0][CNT_W-1:0] cnt
);

  localparam int unsigned CtrlW = DATA_W / 8;
  localparam logic [DATA_W-1:0] IdleD = {CtrlW{XgmiiIdle}};

  function automatic logic is_idle(input logic [DATA_W-1:0] d, input logic [CtrlW-1:0] c);
    logic r;
    r = &c;
    for (int i = 0; i < int'(CtrlW); i++) if (d[8*i +: 8] != XgmiiIdle) r = 1'b0;
    return r;
  endfunction

  // Start may only sit on lane 0 or lane 4 of each 8-byte word.
  function automatic logic is_sof(input logic [DATA_W-1:0] d, input logic [CtrlW-1:0] c);
    logic r;
    r = 1'b0;
    for (int i = 0; i < int'(CtrlW); i++) begin
      if ((i % 4 == 0) && c[i] && (d[8*i +: 8] == XgmiiStart)) r = 1'b1;
    end
    return r;
  endfunction

  function automatic logic is_err(input logic [DATA_W-1:0] d, input logic [CtrlW-1:0] c);
    logic r;
    r = 1'b0;
    for (int i = 0; i < int'(CtrlW); i++) if (c[i] && (d[8*i +: 8] == XgmiiError)) r = 1'b1;
    return r;
  endfunction

  loop_state_e          state_q;
  logic [DATA_W-1:0]    rx_word_d;
  logic [CtrlW-1:0]     rx_ctrl_d;
  logic                 tx_idle, pcs_idle;
  logic [NumCntTyp-1:0] inc;

  assign tx_idle  = is_idle(mac_txd, mac_txc);
  assign pcs_idle = is_idle(pcs_rxd, pcs_rxc);

  // Transitions into LWAIT/UWAIT only fire on an idle input word, so the
  // word selected by the current state is already idle on those edges.
  always_comb begin
    rx_word_d = IdleD;
    rx_ctrl_d = '1;
    unique case (state_q)
      StNorm: begin
        rx_word_d = pcs_rxd;
        rx_ctrl_d = pcs_rxc;
      end
      StLoop: begin
        rx_word_d = mac_txd;
        rx_ctrl_d = mac_txc;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_156 or posedge async_reset) begin
    if (async_reset) begin
      state_q <= StNorm;
      pcs_txd <= IdleD;
      pcs_txc <= '1;
      mac_rxd <= IdleD;
      mac_rxc <= '1;
    end else begin
      pcs_txd <= mac_txd;
      pcs_txc <= mac_txc;
      mac_rxd <= rx_word_d;
      mac_rxc <= rx_ctrl_d;
      unique case (state_q)
        StNorm:  if (loop_req && pcs_idle) state_q <= StLwait;
        StLwait: begin
          if (!loop_req && pcs_idle)     state_q <= StNorm;
          else if (loop_req && tx_idle)  state_q <= StLoop;
        end
        StLoop:  if (!loop_req && tx_idle) state_q <= StUwait;
        StUwait: begin
          if (pcs_idle)                  state_q <= StNorm;
          else if (loop_req && tx_idle)  state_q <= StLoop;
        end
        default: state_q <= StNorm;
      endcase
    end
  end

  assign loop_act = (state_q == StLoop);

  assign inc[CntTxSof] = is_sof(mac_txd, mac_txc);
  assign inc[CntRxSof] = is_sof(rx_word_d, rx_ctrl_d);
  assign inc[CntTxErr] = is_err(mac_txd, mac_txc);
  assign inc[CntRxErr] = is_err(rx_word_d, rx_ctrl_d);

  always_ff @(posedge clk_156 or posedge async_reset) begin
    if (async_reset) begin
      cnt <= '0;
    end else begin
      for (int t = 0; t < int'(NumCntTyp); t++) begin
        if (cnt_clr) begin
          cnt[t] <= '0;
        end else if (inc[t] && (cnt[t] != {CNT_W{1'b1}})) begin
          cnt[t] <= cnt[t] + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/xgmii_loop_mon.sv
// N-channel XGMII interposer between MAC and PCS with per-channel near-end
// loopback and a registered counter readout mux.
module xgmii_loop_mon
  import xgmii_loop_mon_pkg::*;
#(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned CNT_W  = 32
) (
  input  logic                                     clk_156,
  input  logic                                     async_reset,
  input  logic [NUM_CH*DATA_W-1:0]                 mac_txd,
  input  logic [NUM_CH*(DATA_W/8)-1:0]             mac_txc,
  output logic [NUM_CH*DATA_W-1:0]                 pcs_txd,
  output logic [NUM_CH*(DATA_W/8)-1:0]             pcs_txc,
  input  logic [NUM_CH*DATA_W-1:0]                 pcs_rxd,
  input  logic [NUM_CH*(DATA_W/8)-1:0]             pcs_rxc,
  output logic [NUM_CH*DATA_W-1:0]                 mac_rxd,
  output logic [NUM_CH*(DATA_W/8)-1:0]             mac_rxc,
  input  logic [NUM_CH-1:0]                        loop_req,
  output logic [NUM_CH-1:0]                        loop_act,
  input  logic [(NUM_CH > 1 ? $clog2(NUM_CH) : 1)-1:0] cnt_ch_sel,
  input  logic [1:0]                               cnt_typ_sel,
  output logic [CNT_W-1:0]                         cnt_rd_data,
  input  logic                                     cnt_clr
);

  localparam int unsigned CtrlW = DATA_W / 8;

  logic [NUM_CH-1:0][NumCntTyp-1:0][CNT_W-1:0] cnt_all;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    xgmii_loop_mon_chan #(
      .DATA_W (DATA_W),
      .CNT_W  (CNT_W)
    ) u_chan (
      .clk_156     (clk_156),
      .async_reset (async_reset),
      .mac_txd     (mac_txd[k*DATA_W +: DATA_W]),
      .mac_txc     (mac_txc[k*CtrlW +: CtrlW]),
      .pcs_txd     (pcs_txd[k*DATA_W +: DATA_W]),
      .pcs_txc     (pcs_txc[k*CtrlW +: CtrlW]),
      .pcs_rxd     (pcs_rxd[k*DATA_W +: DATA_W]),
      .pcs_rxc     (pcs_rxc[k*CtrlW +: CtrlW]),
      .mac_rxd     (mac_rxd[k*DATA_W +: DATA_W]),
      .mac_rxc     (mac_rxc[k*CtrlW +: CtrlW]),
      .loop_req    (loop_req[k]),
      .loop_act    (loop_act[k]),
      .cnt_clr     (cnt_clr),
      .cnt         (cnt_all[k])
    );
  end

  // Out-of-range channel selects read as zero rather than aliasing a channel.
  always_ff @(posedge clk_156 or posedge async_reset) begin
    if (async_reset) begin
      cnt_rd_data <= '0;
    end else if (32'(cnt_ch_sel) < NUM_CH) begin
      cnt_rd_data <= cnt_all[cnt_ch_sel][cnt_typ_sel];
    end else begin
      cnt_rd_data <= '0;
    end
  end

endmodule
